// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined bidirectional logarithmic shifter with rotate,
// arithmetic fill and sticky generation, behind valid/ready handshakes.
// Left shifts are resolved internally by bit-reversing the operand on entry
// and the result on exit, so every level is a right-shift level.
module barrel_shift_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW:0]     in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky
);

    // Everything that travels with an operand through the pipe.
    typedef struct packed {
        logic             vld;
        logic             dir;
        logic             rot;
        logic             fill;
        logic [SHW:0]     amt;
        logic             stk;
        logic [WIDTH-1:0] dat;
    } stage_t;

    stage_t st_q   [STAGES];
    stage_t st_d   [STAGES];
    stage_t lvl_in [STAGES];
    logic   adv;

    // Levels 0..SHW-1 shift by 2^l, level SHW is the overflow level;
    // they are spread evenly over the register stages.
    function automatic int unsigned stage_of(input int unsigned lvl);
        return (lvl * unsigned'(STAGES)) / unsigned'(SHW + 1);
    endfunction

    assign adv        = out_ready | ~st_q[STAGES-1].vld;
    assign in_ready   = adv;
    assign out_valid  = st_q[STAGES-1].vld;
    assign out_data   = st_q[STAGES-1].dat;
    assign out_sticky = st_q[STAGES-1].stk;

    // Stage inputs: decoded operand for stage 0, previous register otherwise.
    always_comb begin
        lvl_in[0]      = '0;
        lvl_in[0].vld  = in_valid;
        lvl_in[0].dir  = in_dir;
        lvl_in[0].rot  = (in_mode == 2'b10);
        lvl_in[0].fill = (in_mode == 2'b01) && !in_dir && in_data[WIDTH-1];
        lvl_in[0].amt  = in_amt;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            lvl_in[0].dat[i] = in_dir ? in_data[WIDTH-1-i] : in_data[i];
        end
        for (int unsigned s = 1; s < STAGES; s++) begin
            lvl_in[s] = st_q[s-1];
        end
    end

    // Shift levels owned by each stage; the last stage undoes the reversal.
    // The overflow level runs last, so OR-ing what is left of the word into
    // sticky yields the OR of every operand bit when amt >= WIDTH.
    always_comb begin
        stage_t          cur;
        stage_t          nxt;
        logic [SHW-1:0]  src;
        int unsigned     k;
        cur = '0;
        nxt = '0;
        src = '0;
        k   = 0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            cur = lvl_in[s];
            for (int unsigned l = 0; l <= SHW; l++) begin
                nxt = cur;
                if (stage_of(l) == s) begin
                    if (l < SHW) begin
                        if (cur.amt[l]) begin
                            k = 1 << l;
                            for (int unsigned i = 0; i < WIDTH; i++) begin
                                src = SHW'((i + k) % WIDTH);
                                nxt.dat[i] = (cur.rot || (i + k < WIDTH)) ? cur.dat[src] : cur.fill;
                                if (i < k) begin
                                    nxt.stk = nxt.stk | (cur.dat[i] & ~cur.rot);
                                end
                            end
                        end
                    end else if (cur.amt[SHW] && !cur.rot) begin
                        nxt.stk = cur.stk | (|cur.dat);
                        nxt.dat = {WIDTH{cur.fill}};
                    end
                end
                cur = nxt;
            end
            if ((s == STAGES - 1) && cur.dir) begin
                nxt = cur;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    nxt.dat[i] = cur.dat[WIDTH-1-i];
                end
                cur = nxt;
            end
            st_d[s] = cur;
        end
    end

    // Pipeline registers: all stages advance together or all hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                st_q[s] <= '0;
            end
        end else if (adv) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                st_q[s] <= st_d[s];
            end
        end
    end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed and random stimulus for barrel_shift_pipe
// (WIDTH=8, STAGES=2), checked against a behavioural shift model.
module tb_barrel_shift_pipe;

    localparam int W  = 8;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [3:0]   in_amt;
    logic         in_dir;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_sticky;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_stall = -1000;
    bit bp_rand = 1'b0;

    typedef struct {
        logic [8:0] res;
        int         cyc;
    } ent_t;
    ent_t sb[$];
    ent_t e_m;

    typedef struct {
        logic [7:0] d;
        logic [3:0] a;
        logic       dr;
        logic [1:0] m;
        logic [8:0] exp;
    } vec_t;
    vec_t vt[13];

    barrel_shift_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_dir     (in_dir),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result as {sticky, data} from plain integer arithmetic.
    function automatic logic [8:0] ref_shift(input logic [7:0] d, input int amt,
                                             input logic dr, input logic [1:0] m);
        int unsigned v;
        int unsigned r;
        int unsigned a;
        bit          s;
        v = d;
        if (m == 2'b10) begin
            a = amt % W;
            r = dr ? ((v << a) | (v >> (W - a))) : ((v >> a) | (v << (W - a)));
            s = 1'b0;
        end else if (amt >= W) begin
            r = (m == 2'b01 && !dr && d[7]) ? 32'hFF : 32'h0;
            s = (d != 0);
        end else if (dr) begin
            r = v << amt;
            s = ((v >> (W - amt)) != 0);
        end else begin
            r = v >> amt;
            if (m == 2'b01 && d[7]) r = r | (32'hFF << (W - amt));
            s = ((v % (1 << amt)) != 0);
        end
        return {s, r[7:0]};
    endfunction

    // Scoreboard: model on accept, compare whenever a result is presented.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb.delete();
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, out_ready | ~out_valid});
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e_m = sb[0];
                    chk("out_data", {24'd0, out_data}, {24'd0, e_m.res[7:0]});
                    chk("out_sticky", {31'd0, out_sticky}, {31'd0, e_m.res[8]});
                    if (out_ready) begin
                        if (last_stall < e_m.cyc) chk("latency", cyc - e_m.cyc, ST);
                        void'(sb.pop_front());
                    end
                end
                if (!out_ready) last_stall = cyc;
            end
            if (in_valid && in_ready) begin
                e_m.res = ref_shift(in_data, int'(in_amt), in_dir, in_mode);
                e_m.cyc = cyc;
                sb.push_back(e_m);
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [7:0] d, input logic [3:0] a, input logic dr, input logic [1:0] m);
        int n;
        n = 0;
        in_data  = d;
        in_amt   = a;
        in_dir   = dr;
        in_mode  = m;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vt[0]  = '{8'hB6, 4'd3,  1'b0, 2'b00, 9'h116};
        vt[1]  = '{8'h80, 4'd9,  1'b0, 2'b01, 9'h1FF};
        vt[2]  = '{8'h80, 4'd3,  1'b0, 2'b01, 9'h0F0};
        vt[3]  = '{8'h81, 4'd1,  1'b1, 2'b10, 9'h003};
        vt[4]  = '{8'h81, 4'd9,  1'b1, 2'b10, 9'h003};
        vt[5]  = '{8'h81, 4'd1,  1'b0, 2'b10, 9'h0C0};
        vt[6]  = '{8'hF0, 4'd2,  1'b1, 2'b00, 9'h1C0};
        vt[7]  = '{8'hF0, 4'd0,  1'b1, 2'b00, 9'h0F0};
        vt[8]  = '{8'hF0, 4'd8,  1'b1, 2'b00, 9'h100};
        vt[9]  = '{8'h81, 4'd1,  1'b1, 2'b11, 9'h102};
        vt[10] = '{8'h81, 4'd15, 1'b0, 2'b10, 9'h003};
        vt[11] = '{8'h7F, 4'd15, 1'b0, 2'b01, 9'h100};
        vt[12] = '{8'h80, 4'd0,  1'b0, 2'b01, 9'h080};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0;
        in_dir = 1'b0; in_mode = 2'b00; out_ready = 1'b1;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", {24'd0, out_data}, 32'd0);
        chk("reset_out_sticky", {31'd0, out_sticky}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(1);
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Pin the model to hand-computed results, then run the same vectors.
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("model_pin%0d", i),
                {23'd0, ref_shift(vt[i].d, int'(vt[i].a), vt[i].dr, vt[i].m)}, {23'd0, vt[i].exp});
        end
        for (int i = 0; i < 13; i++) begin
            send(vt[i].d, vt[i].a, vt[i].dr, vt[i].m);
            if (i % 4 == 3) idle(2);
        end
        idle(4);

        // Backpressure: three back-to-back, downstream stalled.
        out_ready = 1'b0;
        fork
            begin
                send(8'h01, 4'd0, 1'b0, 2'b00);
                send(8'h02, 4'd0, 1'b0, 2'b00);
                send(8'h04, 4'd0, 1'b0, 2'b00);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_out_hold", {24'd0, out_data}, 32'h01);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);
        chk("bp_drained", sb.size(), 32'd0);

        // Reset with two operands in flight.
        send(8'h11, 4'd0, 1'b0, 2'b00);
        send(8'h22, 4'd0, 1'b0, 2'b00);
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_out_data", {24'd0, out_data}, 32'd0);
        chk("midreset_out_sticky", {31'd0, out_sticky}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(6);
        chk("ready_after_midreset", {31'd0, in_ready}, 32'd1);

        // Random operands under random backpressure.
        bp_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            send(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        bp_rand = 1'b0;
        idle(1);
        out_ready = 1'b1;
        idle(10);
        chk("final_drain", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/barrel_shift_pipe.md
# barrel_shift_pipe

Parametrised, pipelined bidirectional barrel shifter with rotate, arithmetic-shift and sticky-bit generation. It generalises the team's fixed 8-input forward/reverse select mux into a WIDTH-bit logarithmic shifter. The block serves the floating-point adder/subtractor datapath for exponent-alignment right shifts and post-add normalisation left shifts. Operands enter and results leave on valid/ready handshakes, with a fixed latency of STAGES cycles when not stalled.

## Interface
- WIDTH, 32, data width; power of two, ≥4.
- SHW, $clog2(WIDTH), derived localparam (not overridable).
- STAGES, 2, pipeline register stages, 1..SHW+1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  block accepts operand this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW+1  shift amount, 0..2*WIDTH-1.
- in_dir  in  1  0 = right, 1 = left.
- in_mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  shifted result.
- out_sticky  out  1  OR of all operand bits discarded by the shift.

## Operation
- Logical right: out = in_data >> amt. Zeros fill at the MSB end. sticky = |in_data[amt-1:0].
- Arithmetic right: same shift, but fill bits are copies of in_data[WIDTH-1]. Sticky is as for logical right.
- Logical or arithmetic left: out = in_data << amt. Zeros fill at the LSB end. sticky = |in_data[WIDTH-1:WIDTH-amt].
- Rotate (either direction): the effective amount is amt mod WIDTH (low SHW bits). No bits are lost, so sticky = 0.
- amt ≥ WIDTH with a non-rotate mode:
  - Every operand bit is discarded.
  - out = fill pattern: all zeros, or all in_data[WIDTH-1] for arithmetic right.
  - sticky = |in_data.
- amt = 0: out = in_data, sticky = 0, for every mode.
- Arithmetic left is identical to logical left.
- Datapath structure:
  - SHW shift levels (shift by 2^j) plus one overflow level (amt[SHW]).
  - Levels are split across STAGES register stages in any partition; only end-to-end latency is observable.
  - Direction, mode, amount bits not yet consumed, and the partial sticky travel with the data.
- Bit order and direction are resolved inside the shifter; no external reversal is required.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sticky = 0, all stage valid bits = 0.
- in_ready is 1 from the first clock after rst_n deasserts.
- Global advance signal: adv = out_ready | ~out_valid. in_ready = adv (combinational from out_ready).
- While adv = 1, every stage register loads from the stage before it. Stage 0 loads {in_valid, operand}.
- While adv = 0, every stage holds, including bubbles.
- An operand is accepted when in_valid & in_ready. With out_ready held high, its result appears on out_valid exactly STAGES cycles later.
- Throughput: one result per cycle with out_ready held high.
- out_data and out_sticky are registered and stay stable while out_valid & ~out_ready.
- Ordering is strictly FIFO: no loss or duplication under any out_ready pattern.
- Asserting rst_n mid-operation discards all in-flight operands immediately. Outputs return to their reset values asynchronously.
- Reserved mode 11 must never produce X; it behaves as logical.

## Test plan
- WIDTH=8, STAGES=2, logical right, 0xB6, amt 3 → out 0x16, sticky 1, 2 cycles after accept.
- Arithmetic right, 0x80, amt 9 → out 0xFF, sticky 1. Same with amt 3 → 0xF0, sticky 0.
- Rotate left, 0x81, amt 1 → 0x03, sticky 0. amt 9 → 0x03. Rotate right, 0x81, amt 1 → 0xC0.
- Logical left, 0xF0, amt 2 → 0xC0, sticky 1. amt 0 → 0xF0, sticky 0. amt 8 → 0x00, sticky 1.
- Backpressure: issue 0x01, 0x02, 0x04 back-to-back (right logical amt 0), hold out_ready = 0 for 5 cycles → in_ready low, out_data held at 0x01. On release, results come out in order 0x01, 0x02, 0x04 on consecutive cycles.
- Reset mid-flight: with 2 operands in the pipe, pulse rst_n low asynchronously → out_valid = 0 at once, and no stale result appears after release.
